retire_trace_collector: RTL
===========================

Name: retire_trace_collector

Overview:
Consumer end of the pipeline's write-back debug interface (wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite). Captures each retired instruction into a record FIFO and drains it through a valid/ready stream to a checker, UART dumper or testbench. Keeps a retired-instruction count and a saturating dropped-record count. Sits beside pipeline_topo in the top level, purely observational, with no feedback into the core.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 32, retire counter width
DROP_W, 16, drop counter width (saturating)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
enable  in  1  capture enable; 0 = ignore wb_* (counters hold)
wb_valid  in  1  WB stage holds a real retiring instruction this cycle (bubbles/flushes = 0)
wb_pc  in  32  PC of retiring instruction
wb_instruction  in  32  instruction word
wb_write_data  in  32  value written to register file
wb_rd_addr  in  5  destination register
wb_RegWrite  in  1  register write enable
tr_valid  out  1  head record available
tr_ready  in  1  consumer accepts head record
tr_pc  out  32  head record PC
tr_instruction  out  32  head record instruction
tr_write_data  out  32  head record write data (0 when tr_regwrite = 0)
tr_rd_addr  out  5  head record rd
tr_regwrite  out  1  head record architectural write flag
retire_count  out  CNT_W  instructions seen retiring while enabled
drop_count  out  DROP_W  records lost to full FIFO, saturating
overflow  out  1  sticky: set on first drop

Behaviour:
- Reset (reset==0 at clk edge): FIFO empty; tr_valid=0; all tr_* data outputs 0; retire_count=0; drop_count=0; overflow=0. A reset mid-drain discards all stored records; pending tr_ready has no effect that cycle.
- Capture event: cap = enable & wb_valid, sampled each rising edge.
- Record normalisation on capture: regwrite_n = wb_RegWrite & (wb_rd_addr != 0). Writes to x0 are stored as regwrite=0 and write_data=0, with rd kept as given. write_data is stored as 0 whenever regwrite_n = 0.
- retire_count increments by 1 on every cap, independent of FIFO space, and wraps modulo 2^CNT_W.
- Push: on cap when not full, or when full and a pop occurs the same cycle (pop frees the slot first).
- Drop: on cap when full and no pop that cycle. drop_count increments and saturates at all-ones. overflow is set and stays set until reset.
- Pop: tr_valid & tr_ready at the edge. Head advances.
- Output is first-word-fall-through from registered storage. A record captured at edge N appears on tr_* with tr_valid=1 after edge N, so latency is 1 cycle from wb_* sampling to visibility.
- tr_* data must stay stable while tr_valid=1 and tr_ready=0. tr_* holds the last value (don't-care to consumer) when tr_valid=0.
- Pointers: log2(DEPTH)+1 bits, with the extra bit distinguishing full from empty. Wrap-around is natural modulo 2·DEPTH. full = (wr[msb]!=rd[msb]) & equal low bits. empty = pointers equal.
- Simultaneous push and pop when empty: the push wins, the pop cannot occur because tr_valid=0, and the count becomes 1.
- Simultaneous push and pop at count k (0<k<=DEPTH): the count stays k and no drop occurs.
- enable low: no capture, no counting. Draining continues normally.
- No combinational path from wb_* to tr_*. tr_ready affects only the internal state and is not combinationally routed to any output.

Decomposition:
- Shared package (trace_pkg): record field widths (XLEN=32, REG_ADDR_W=5), record struct/concatenation order {pc, instruction, write_data, rd, regwrite} = 102 bits, and the record-normalisation function.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/wdata/rdata, FWFT). The top handles normalisation, counters, drop logic and sticky overflow.

Test Plan:
- Reset then 3 caps (pc 0x0,0x4,0x8; rd=5, RegWrite=1, data 0xA,0xB,0xC) with tr_ready=1 -> three records in order one cycle after each capture; retire_count=3; drop_count=0.
- Cap with rd=0, RegWrite=1, data 0xDEADBEEF -> tr_regwrite=0, tr_write_data=0, tr_rd_addr=0; retire_count still increments.
- tr_ready=0, 10 consecutive caps with DEPTH=8 -> 8 records stored, drop_count=2, overflow=1, retire_count=10. Then drain gives the first 8 PCs in order; overflow remains 1.
- FIFO full, tr_ready=1 and cap in the same cycle for 5 cycles -> no drops; occupancy stays 8; output order preserved.
- tr_ready held 0 with tr_valid=1 for 4 cycles -> tr_* constant. Assert reset=0 for one edge mid-stream -> tr_valid=0 and all counters 0 on the next cycle.
- enable=0 with wb_valid=1 for 6 cycles -> no records; retire_count unchanged. Force drop_count to saturation (DROP_W=4 build, 20 drops) -> stays 15.

Source files
------------

// File: rtl/retire_trace_collector_pkg.sv
// trace_pkg: retire record layout and write-back normalisation shared by the collector.
package trace_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       instruction;
        logic [XLEN-1:0]       write_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // Writes to x0 are not architectural, so they are recorded as no-write with zero data.
    function automatic trace_rec_t normalise(
        input logic [XLEN-1:0]       pc,
        input logic [XLEN-1:0]       instruction,
        input logic [XLEN-1:0]       write_data,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  regwrite
    );
        trace_rec_t r;
        r.pc          = pc;
        r.instruction = instruction;
        r.regwrite    = regwrite && (rd != '0);
        r.write_data  = r.regwrite ? write_data : '0;
        r.rd          = rd;
        return r;
    endfunction
endpackage

// File: rtl/retire_trace_collector_fifo.sv
// sync_fifo: first-word-fall-through FIFO with wrap-bit pointers and cleared storage on reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr, rd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd[AW-1:0]];

    // Storage is cleared so the head reads as zero straight after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr <= '0;
            rd <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr[AW-1:0]] <= wdata;
                wr <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
        end
    end
endmodule

// File: rtl/retire_trace_collector.sv
// retire_trace_collector: captures retiring write-back records into a FIFO streamed out over valid/ready,
// with retire/drop counters and a sticky overflow flag.
module retire_trace_collector
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wb_valid,
    input  logic [31:0]       wb_pc,
    input  logic [31:0]       wb_instruction,
    input  logic [31:0]       wb_write_data,
    input  logic [4:0]        wb_rd_addr,
    input  logic              wb_RegWrite,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [31:0]       tr_pc,
    output logic [31:0]       tr_instruction,
    output logic [31:0]       tr_write_data,
    output logic [4:0]        tr_rd_addr,
    output logic              tr_regwrite,
    output logic [CNT_W-1:0]  retire_count,
    output logic [DROP_W-1:0] drop_count,
    output logic              overflow
);
    trace_rec_t rec, head;
    logic       cap, pop, full, empty;

    assign cap = enable && wb_valid;
    assign pop = !empty && tr_ready;
    assign rec = normalise(wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite);

    sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap),
        .pop   (pop),
        .wdata (rec),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign tr_valid       = !empty;
    assign tr_pc          = head.pc;
    assign tr_instruction = head.instruction;
    assign tr_write_data  = head.write_data;
    assign tr_rd_addr     = head.rd;
    assign tr_regwrite    = head.regwrite;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (cap) retire_count <= retire_count + 1'b1;
            // A same-cycle pop frees the slot, so only full-without-pop loses the record.
            if (cap && full && !pop) begin
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
                overflow <= 1'b1;
            end
        end
    end
endmodule
